// File: rtl/button_debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module   : button_debounce_pkg
// Brief    : Shared register offsets, counter width and CONFIG layout for the
//            button debounce peripheral.
// Revision : 1.0 - initial release
// ============================================================================
package button_debounce_pkg;

    localparam logic [1:0] REG_STATE   = 2'd0;
    localparam logic [1:0] REG_PRESS   = 2'd1;
    localparam logic [1:0] REG_RELEASE = 2'd2;
    localparam logic [1:0] REG_CONFIG  = 2'd3;

    localparam int CNT_W = 8;

    typedef struct packed {
        logic [7:0]       irq_en;
        logic [CNT_W-1:0] thresh;
    } config_t;

    // Expand per-byte write strobes into a 32-bit bit mask.
    function automatic logic [31:0] byte_mask(input logic [3:0] mask);
        return {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    endfunction

endpackage

`default_nettype wire

// File: rtl/button_debounce_if.sv
`default_nettype none
// ============================================================================
// Module   : button_debounce_if
// Brief    : Common memory bus slot for the button peripheral.
// Revision : 1.0 - initial release
// ============================================================================
interface button_debounce_if;

    logic [31:0] address_in;
    logic        sel_in;
    logic [31:0] read_value_out;
    logic [3:0]  write_mask_in;
    logic [31:0] write_value_in;
    logic        ready_out;

    modport master (
        output address_in,
        output sel_in,
        output write_mask_in,
        output write_value_in,
        input  read_value_out,
        input  ready_out
    );

    modport slave (
        input  address_in,
        input  sel_in,
        input  write_mask_in,
        input  write_value_in,
        output read_value_out,
        output ready_out
    );

endinterface

`default_nettype wire

// File: rtl/button_debounce_chan.sv
`default_nettype none
// ============================================================================
// Module   : button_debounce_chan
// Brief    : One button: two-flop synchroniser, tick-driven debounce counter,
//            debounced level and rise/fall pulses aligned with its update.
// Revision : 1.0 - initial release
// ============================================================================
module button_debounce_chan
    import button_debounce_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_button,
    input  logic             i_tick,
    input  logic [CNT_W-1:0] i_thresh,
    input  logic             i_clr_cnt,
    output logic             o_stable,
    output logic             o_rise,
    output logic             o_fall
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;

    logic [CNT_W:0]   w_cnt_inc;
    logic             w_next_stable;
    logic [CNT_W-1:0] w_next_cnt;

    assign w_cnt_inc = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};

    // A zero threshold bypasses the debounce so the level follows the
    // synchronised pin directly.
    always_comb begin
        w_next_stable = r_stable;
        w_next_cnt    = r_cnt;
        if (i_thresh == '0) begin
            w_next_stable = r_sync2;
            w_next_cnt    = '0;
        end else if (i_clr_cnt || (r_sync2 == r_stable)) begin
            w_next_cnt = '0;
        end else if (i_tick) begin
            if (w_cnt_inc >= {1'b0, i_thresh}) begin
                w_next_stable = r_sync2;
                w_next_cnt    = '0;
            end else if (r_cnt == CNT_MAX) begin
                w_next_cnt = r_cnt;
            end else begin
                w_next_cnt = w_cnt_inc[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1  <= i_button;
            r_sync2  <= r_sync1;
            r_stable <= w_next_stable;
            r_cnt    <= w_next_cnt;
        end
    end

    assign o_stable = r_stable;
    assign o_rise   = w_next_stable & ~r_stable;
    assign o_fall   = ~w_next_stable & r_stable;

endmodule

`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module   : button_debounce
// Brief    : Memory-mapped debounced button peripheral with sticky W1C
//            press/release flags. Define BUTTON_DEBOUNCE_IRQ_EN to enable
//            the per-button interrupt enables and irq_out.
// Revision : 1.0 - initial release
// ============================================================================
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int BUTTONCOUNT    = 4,
    parameter int FREQ           = 36000000,
    parameter int DEFAULT_THRESH = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [BUTTONCOUNT-1:0] buttons_in,
    button_debounce_if.slave       bus,
    output logic                   irq_out
);

    localparam int TICK_PERIOD = FREQ / 1000;
    localparam int PRESC_W     = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_PERIOD - 1);
    localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);

    logic [PRESC_W-1:0]     r_presc;
    logic                   w_tick;

    logic [1:0]             w_reg;
    logic                   w_wr;
    logic [31:0]            w_wdata;
    logic [BUTTONCOUNT-1:0] w_press_clr;
    logic [BUTTONCOUNT-1:0] w_release_clr;
    logic                   w_thresh_wr;

    logic [BUTTONCOUNT-1:0] w_stable;
    logic [BUTTONCOUNT-1:0] w_rise;
    logic [BUTTONCOUNT-1:0] w_fall;

    logic [BUTTONCOUNT-1:0] r_press;
    logic [BUTTONCOUNT-1:0] r_release;
    logic [CNT_W-1:0]       r_thresh;
    logic [7:0]             w_irq_en;
    config_t                w_cfg;
    logic                   w_unused;

    // 1 ms tick prescaler
    assign w_tick = (r_presc == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PRESC_ONE;
        end
    end

    // Bus decode
    assign w_reg         = bus.address_in[3:2];
    assign w_wr          = bus.sel_in && (bus.write_mask_in != 4'd0);
    assign w_wdata       = bus.write_value_in & byte_mask(bus.write_mask_in);
    assign w_press_clr   = (w_wr && (w_reg == REG_PRESS))   ? w_wdata[BUTTONCOUNT-1:0] : '0;
    assign w_release_clr = (w_wr && (w_reg == REG_RELEASE)) ? w_wdata[BUTTONCOUNT-1:0] : '0;
    assign w_thresh_wr   = w_wr && (w_reg == REG_CONFIG) && bus.write_mask_in[0];

    generate
        for (genvar g = 0; g < BUTTONCOUNT; g++) begin : g_chan
            button_debounce_chan u_chan (
                .clk       (clk),
                .reset     (reset),
                .i_button  (buttons_in[g]),
                .i_tick    (w_tick),
                .i_thresh  (r_thresh),
                .i_clr_cnt (w_thresh_wr),
                .o_stable  (w_stable[g]),
                .o_rise    (w_rise[g]),
                .o_fall    (w_fall[g])
            );
        end
    endgenerate

    // Hardware set is OR-ed in after the W1C clear so a coincident event wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_press   <= '0;
            r_release <= '0;
            r_thresh  <= CNT_W'(DEFAULT_THRESH);
        end else begin
            r_press   <= (r_press & ~w_press_clr) | w_rise;
            r_release <= (r_release & ~w_release_clr) | w_fall;
            if (w_thresh_wr) begin
                r_thresh <= w_wdata[CNT_W-1:0];
            end
        end
    end

`ifdef BUTTON_DEBOUNCE_IRQ_EN
    logic [7:0]             r_irq_en;
    logic                   r_irq;
    logic [BUTTONCOUNT-1:0] w_irq_en_bits;

    // irq_en only spans eight buttons; any higher channels stay masked.
    generate
        for (genvar g = 0; g < BUTTONCOUNT; g++) begin : g_irq_en
            if (g < 8) begin : g_lo
                assign w_irq_en_bits[g] = r_irq_en[g];
            end else begin : g_hi
                assign w_irq_en_bits[g] = 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_en <= 8'd0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr && (w_reg == REG_CONFIG) && bus.write_mask_in[1]) begin
                r_irq_en <= bus.write_value_in[15:8];
            end
            r_irq <= |((r_press | r_release) & w_irq_en_bits);
        end
    end

    assign w_irq_en = r_irq_en;
    assign irq_out  = r_irq;
`else
    assign w_irq_en = 8'd0;
    assign irq_out  = 1'b0;
`endif

    assign w_cfg = '{irq_en: w_irq_en, thresh: r_thresh};

    // Read path is purely combinational and forced to zero when unselected.
    always_comb begin
        bus.read_value_out = 32'd0;
        if (bus.sel_in) begin
            case (w_reg)
                REG_STATE:   bus.read_value_out = 32'(w_stable);
                REG_PRESS:   bus.read_value_out = 32'(r_press);
                REG_RELEASE: bus.read_value_out = 32'(r_release);
                REG_CONFIG:  bus.read_value_out = {16'd0, w_cfg};
                default:     bus.read_value_out = 32'd0;
            endcase
        end
    end

    assign bus.ready_out = bus.sel_in;

    assign w_unused = &{1'b0, bus.address_in[31:4], bus.address_in[1:0], w_wdata};

endmodule

`default_nettype wire

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Memory-mapped button input peripheral on the SoC common memory bus.
- Sits between the raw board button pins and the bus read-data OR mux, at the 0x00010004 button window widened to 16 bytes.
- Synchronises and debounces each button on a 1 ms tick.
- Exposes debounced levels plus sticky press/release event flags that software clears with write-1-to-clear.

Parameters:
- BUTTONCOUNT, 4, number of button inputs (1..16)
- FREQ, 36000000, clk frequency in Hz; 1 ms tick period = FREQ/1000 cycles (must be >= 1)
- DEFAULT_THRESH, 10, reset value of CONFIG.thresh (ms)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- buttons_in  in  BUTTONCOUNT  raw asynchronous button pins
- address_in  in  32  bus address; only bits [3:2] decoded
- sel_in  in  1  peripheral select from top-level decode
- read_value_out  out  32  read data; all zeros when sel_in=0
- write_mask_in  in  4  byte write strobes; 0 = read
- write_value_in  in  32  write data
- ready_out  out  1  equals sel_in (single-cycle access)
- irq_out  out  1  level interrupt (see Optional Feature)

Behaviour:
- Reset values:
  - Sync flops, counters, STATE, PRESS, RELEASE: all 0.
  - CONFIG.thresh = DEFAULT_THRESH.
  - Prescaler = 0; irq_out = 0.
  - read_value_out is combinational and therefore 0 when sel_in=0.
- Tick: prescaler counts 0..FREQ/1000-1; tick pulses for one cycle on wrap.
- Per button:
  - Two-flop synchroniser feeds a debounce counter (8 bits).
  - If synced == stable: counter cleared.
  - Else, on each tick: counter+1; when counter+1 >= thresh, stable <= synced and counter cleared.
- thresh = 0: stable <= synced on the next clk (bypass, no tick wait).
- Latency from pin edge to STATE change, pin held constant: 2 clk sync + between thresh-1 and thresh tick periods + 1 clk.
- Events:
  - stable 0->1 sets PRESS[i].
  - stable 1->0 sets RELEASE[i].
  - Both flags are sticky.
- Register map (byte offset = address_in[3:2]*4):
  - 0x0 STATE: RO, debounced levels in [BUTTONCOUNT-1:0]; writes ignored.
  - 0x4 PRESS: W1C.
  - 0x8 RELEASE: W1C.
  - 0xC CONFIG: [7:0] thresh (RW via write_mask_in[0]); [15:8] irq_en (see feature); other bits read 0.
- Unused upper bits always read 0.
- A write is any nonzero write_mask_in with sel_in=1, applied at the clk edge; only the masked bytes take effect.
- Simultaneous hardware set and software W1C of the same flag in one cycle: set wins, flag stays 1.
- CONFIG.thresh write clears all debounce counters in the same cycle; STATE is unaffected.
- Counter saturates at 255; never wraps.
- Reset mid-debounce discards progress; STATE returns to 0 even if buttons are held. A held button then produces a PRESS event after re-debounce.

Optional Feature:
- Macro: BUTTON_DEBOUNCE_IRQ_EN
- Defined:
  - CONFIG[15:8] irq_en is RW (write_mask_in[1]), reset 0.
  - irq_out registered = |((PRESS | RELEASE) & irq_en[BUTTONCOUNT-1:0]); asserts 1 clk after the flag sets.
  - irq_out deasserts 1 clk after the W1C write clears the last enabled flag.
- Undefined: irq_en reads 0, writes ignored, irq_out tied 0, no irq flops.

Decomposition:
- Package button_debounce_pkg:
  - Register offset constants: REG_STATE=2'd0, REG_PRESS=2'd1, REG_RELEASE=2'd2, REG_CONFIG=2'd3.
  - CNT_W=8.
  - Typedef config_t (thresh, irq_en).
- Sub-module button_debounce_chan: one button; synchroniser, counter, stable bit, rise/fall pulses; inputs tick, thresh, clr_cnt.
- Instantiate the sub-module with a generate loop over BUTTONCOUNT.
- Top handles prescaler, register file, bus decode and irq.

Test Plan (bench uses FREQ=4000, so tick = every 4 clk; DEFAULT_THRESH=3):
- Reset, read 0x0/0x4/0x8/0xC -> 0, 0, 0, 0x00000003; ready_out=1 only on cycles with sel_in=1.
- Hold buttons_in=4'b0001 for 40 clk:
  - STATE becomes 0x1 after <= 2+12+1 clk, not before 2+8 clk.
  - PRESS=0x1.
  - A glitch of 5 clk on bit1 never changes STATE.
- Release bit0 -> RELEASE=0x1 after debounce; write 0x1 to 0x8 -> RELEASE reads 0; PRESS still 0x1.
- W1C of PRESS bit2 in the same cycle bit2's stable rises -> PRESS[2]=1 afterwards.
- Write CONFIG=0 (mask 4'b0001), toggle bit3 -> STATE[3] follows synced input with 3 clk latency, no tick wait.
- With BUTTON_DEBOUNCE_IRQ_EN:
  - Write CONFIG=0x0203, press bit1 -> irq_out=1 one clk after PRESS[1]=1.
  - Write 0x2 to 0x4 -> irq_out=0 next clk.
  - Press bit0 (not enabled) -> irq_out stays 0.
